multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32I core, the planned successor to the single-cycle processor. It sequences a shared-memory datapath (one memory for instructions and data, one ALU reused for PC+4, address generation and execution) across several cycles per instruction. It drives all mux selects and write enables, decodes the ALU operation, waits on a memory-ready handshake, and counts retired instructions. Supported ops: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
CNT_W, 32, width of retired-instruction counter instret (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  PC register enable
adr_src  out  1  memory address: 0=PC, 1=result
mem_write  out  1  memory write strobe
ir_write  out  1  IR/OldPC enable
result_src  out  2  00=ALUOut, 01=read data, 10=ALU result
alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1
alu_src_b  out  2  00=RD2, 01=ImmExt, 10=const 4
imm_src  out  2  00=I, 01=S, 10=B, 11=J (combinational from op; don't-care for R)
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse on the last cycle of each legal instruction
illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode
instret  out  CNT_W  retired-instruction count

Behaviour:
- Moore FSM; outputs are decoded from the state only, except pc_write (uses zero), the fetch gating on mem_ready, and imm_src/alu_control (op, funct).
- States and per-state outputs (unlisted enables 0, selects 0):
  FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp=add, result_src=10; ir_write=pc_update=mem_ready. Stays in FETCH while mem_ready=0, else -> DECODE.
  DECODE: alu_src_a=01, alu_src_b=01, add. op 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH with illegal_instr=1.
  MEMADR: src_a=10, src_b=01, add. lw -> MEMREAD, sw -> MEMWRITE.
  MEMREAD: adr_src=1, result_src=00. Stays while mem_ready=0, else -> MEMWB.
  MEMWB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
  MEMWRITE: adr_src=1, result_src=00, mem_write=1, held until mem_ready=1; instr_done=mem_ready; -> FETCH when mem_ready=1.
  EXECUTER: src_a=10, src_b=00, ALUOp=funct -> ALUWB. EXECUTEI: src_a=10, src_b=01, ALUOp=funct -> ALUWB.
  ALUWB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
  BEQ: src_a=10, src_b=00, sub, result_src=00, branch=1, instr_done=1 -> FETCH.
  JAL: src_a=01, src_b=10, add, result_src=00, pc_update=1 -> ALUWB.
- pc_write = pc_update | (branch & zero).
- ALU decode, ALUOp=funct: funct3 000 -> sub if (op[5] & funct7b5), else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- Latencies with mem_ready=1: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one.
- instret increments by 1 on every instr_done cycle and is never incremented by an illegal opcode.
- Reset: at the next edge, state=FETCH and instret=0. While reset=1, pc_write, ir_write, mem_write, reg_write, instr_done and illegal_instr are forced to 0; selects take their FETCH values. A reset mid-instruction abandons it with no write and no count.

Decomposition:
- Package riscv_ctrl_pkg: opcode constants, state enum, ALU control codes, and the result_src/alu_src/imm_src select codes.
- Sub-module alu_decoder (combinational: ALUOp, funct3, funct7b5, op[5] -> alu_control). Shared later by the pipelined core.

Test Plan:
- Reset, then lw (op=0000011), mem_ready=1 -> states F,D,MA,MR,MWB; reg_write=1 only in cycle 5; instret 0->1.
- sw (op=0100011) with mem_ready=0 for the first 2 MEMWRITE cycles -> mem_write high for 3 cycles; instr_done pulses on the 3rd; total 6 cycles.
- R-type funct3=000, funct7b5=1 -> alu_control=001 in EXECUTER. Same with funct7b5=0 -> 000. addi (op=0010011) with funct7b5=1 -> 000. funct3=010 -> 101.
- beq with zero=1 -> pc_write=1 in BEQ. With zero=0 -> pc_write=0. Both take 3 cycles; imm_src=10.
- jal -> F,D,JAL,ALUWB; pc_write=1 in FETCH and JAL; reg_write=1 in ALUWB; imm_src=11.
- op=0000000 -> illegal_instr=1 in DECODE, then FETCH, instret unchanged. Reset asserted during MEMWRITE -> mem_write=0 that cycle, FETCH next, instret=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core:
// opcodes, FSM states, ALU codes and datapath select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    unique case (1'b1)
      (op == OP_SW):  sel = IMM_S;
      (op == OP_BEQ): sel = IMM_B;
      (op == OP_JAL): sel = IMM_J;
      default:        sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder; combinational, reused by the pipelined core.
// Subtract only for R-type funct3=000 with funct7b5 set.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (1'b1)
          (funct3 == 3'b000):
            alu_control = (op_b5 & funct7b5)
                        ? ALU_SUB : ALU_ADD;
          (funct3 == 3'b010): alu_control = ALU_SLT;
          (funct3 == 3'b110): alu_control = ALU_OR;
          (funct3 == 3'b111): alu_control = ALU_AND;
          default:            alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences the
// shared-memory datapath and counts retired instructions.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret
);

  state_t  state, state_nxt;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)           instret <= '0;
    else if (instr_done) instret <= instret + 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    unique case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  state_nxt = S_MEMADR;
          (op == OP_R):   state_nxt = S_EXECUTER;
          (op == OP_I):   state_nxt = S_EXECUTEI;
          (op == OP_JAL): state_nxt = S_JAL;
          (op == OP_BEQ): state_nxt = S_BEQ;
          default: begin
            illegal_instr = 1'b1;
            state_nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_nxt = (op == OP_LW) ? S_MEMREAD
                                  : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Reset kills all side effects and parks selects at FETCH.
    if (reset) begin
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      result_src    = RES_ALU;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_FOUR;
      alu_op        = ALUOP_ADD;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
    end
  end

  assign pc_write = pc_update | (branch & zero);
  assign imm_src  = imm_sel(op);

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op_b5       (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and
// randomized instructions against a latency/effect model.
module tb_multicycle_controller;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  imm_src;
  logic [2:0]  alu_control;
  logic        reg_write;
  logic        instr_done;
  logic        illegal_instr;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .reg_write     (reg_write),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr),
    .instret       (instret)
  );

  function automatic logic is_legal(input logic [6:0] o);
    return o == T_LW || o == T_SW || o == T_R ||
           o == T_I || o == T_JAL || o == T_BEQ;
  endfunction

  // Architectural latency with no memory stalls.
  function automatic int base_cycles(input logic [6:0] o);
    case (o)
      T_LW:    return 5;
      T_BEQ:   return 3;
      T_SW, T_R, T_I, T_JAL: return 4;
      default: return 2;
    endcase
  endfunction

  // ALU code expected in the third cycle of an instruction.
  function automatic logic [2:0] exp_alu(input logic [6:0] o,
                                         input logic [2:0] f3,
                                         input logic f7);
    if (o == T_BEQ) return 3'b001;
    if (o != T_R && o != T_I) return 3'b000;
    case (f3)
      3'b000:  return (o == T_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      T_SW:    return 2'b01;
      T_BEQ:   return 2'b10;
      T_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z,
                           input int sf, input int sm,
                           input string name);
    int  n, rw, mw, pw, iw, dn, il, exp_cyc, exp_rw, exp_mw, exp_pw;
    logic done, last_rw;
    logic [2:0] alu_obs;
    logic [1:0] imm_obs;
    logic is_mem;
    n = 0; rw = 0; mw = 0; pw = 0; iw = 0; dn = 0; il = 0;
    done = 1'b0; last_rw = 1'b0; alu_obs = 'x; imm_obs = 'x;
    is_mem = (o == T_LW || o == T_SW);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    while (!done && n < 40) begin
      if (n < sf) mem_ready = 1'b0;
      else if (is_mem && n >= sf + 3 && n < sf + 3 + sm)
        mem_ready = 1'b0;
      else mem_ready = 1'b1;
      @(negedge clk);
      rw += int'(reg_write);
      mw += int'(mem_write);
      pw += int'(pc_write);
      iw += int'(ir_write);
      dn += int'(instr_done);
      il += int'(illegal_instr);
      if (n == sf + 1) imm_obs = imm_src;
      if (n == sf + 2) alu_obs = alu_control;
      if (instr_done || illegal_instr) begin
        done = 1'b1;
        last_rw = reg_write;
      end
      @(posedge clk); #1;
      n++;
    end
    exp_cyc = base_cycles(o) + sf + (is_mem ? sm : 0);
    exp_rw  = (o == T_LW || o == T_R || o == T_I || o == T_JAL) ? 1 : 0;
    exp_mw  = (o == T_SW) ? sm + 1 : 0;
    exp_pw  = 1 + ((o == T_JAL) ? 1 : 0) + ((o == T_BEQ && z) ? 1 : 0);
    if (!is_legal(o)) begin
      exp_pw = 1;
      exp_rw = 0;
    end
    if (is_legal(o)) exp_instret = exp_instret + 1;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no completion after %0d cycles", name, n);
    end
    checks++;
    if (n !== exp_cyc) begin
      errors++;
      $display("FAIL %s cycles: got %0d want %0d", name, n, exp_cyc);
    end
    checks++;
    if (rw !== exp_rw || (exp_rw == 1 && last_rw !== 1'b1)) begin
      errors++;
      $display("FAIL %s reg_write: got %0d (last %b) want %0d",
               name, rw, last_rw, exp_rw);
    end
    checks++;
    if (mw !== exp_mw) begin
      errors++;
      $display("FAIL %s mem_write cycles: got %0d want %0d", name, mw, exp_mw);
    end
    checks++;
    if (pw !== exp_pw) begin
      errors++;
      $display("FAIL %s pc_write cycles: got %0d want %0d", name, pw, exp_pw);
    end
    checks++;
    if (iw !== 1) begin
      errors++;
      $display("FAIL %s ir_write cycles: got %0d want 1", name, iw);
    end
    checks++;
    if (dn !== (is_legal(o) ? 1 : 0) || il !== (is_legal(o) ? 0 : 1)) begin
      errors++;
      $display("FAIL %s done/illegal: got %0d/%0d want %0d/%0d", name,
               dn, il, is_legal(o) ? 1 : 0, is_legal(o) ? 0 : 1);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL %s instret: got %0d want %0d", name, instret, exp_instret);
    end
    if (is_legal(o)) begin
      checks++;
      if (alu_obs !== exp_alu(o, f3, f7)) begin
        errors++;
        $display("FAIL %s alu_control: got %b want %b",
                 name, alu_obs, exp_alu(o, f3, f7));
      end
      if (o != T_R) begin
        checks++;
        if (imm_obs !== exp_imm(o)) begin
          errors++;
          $display("FAIL %s imm_src: got %b want %b",
                   name, imm_obs, exp_imm(o));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; op = T_LW;
    funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pc_write, ir_write, mem_write, reg_write,
         instr_done, illegal_instr} !== 6'b0) begin
      errors++;
      $display("FAIL reset enables: got %b want 000000",
               {pc_write, ir_write, mem_write, reg_write,
                instr_done, illegal_instr});
    end
    checks++;
    if (alu_src_b !== 2'b10 || result_src !== 2'b10 ||
        alu_src_a !== 2'b00 || adr_src !== 1'b0) begin
      errors++;
      $display("FAIL reset selects: got a=%b b=%b res=%b adr=%b want 00 10 10 0",
               alu_src_a, alu_src_b, result_src, adr_src);
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++;
      $display("FAIL reset instret: got %0d want 0", instret);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_lw();
    run_instr(T_LW, 3'b010, 1'b0, 1'b0, 0, 0, "lw");
  endtask

  task automatic test_sw_stall();
    run_instr(T_SW, 3'b010, 1'b0, 1'b0, 0, 2, "sw_stall");
    run_instr(T_LW, 3'b010, 1'b0, 1'b0, 1, 2, "lw_stall");
  endtask

  task automatic test_alu_decode();
    run_instr(T_R, 3'b000, 1'b1, 1'b0, 0, 0, "r_sub");
    run_instr(T_R, 3'b000, 1'b0, 1'b0, 0, 0, "r_add");
    run_instr(T_I, 3'b000, 1'b1, 1'b0, 0, 0, "addi_f7");
    run_instr(T_R, 3'b010, 1'b0, 1'b0, 0, 0, "r_slt");
    run_instr(T_I, 3'b110, 1'b0, 1'b0, 0, 0, "ori");
    run_instr(T_R, 3'b111, 1'b0, 1'b0, 0, 0, "r_and");
  endtask

  task automatic test_beq();
    run_instr(T_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, "beq_taken");
    run_instr(T_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, "beq_not");
  endtask

  task automatic test_jal();
    run_instr(T_JAL, 3'b000, 1'b0, 1'b0, 0, 0, "jal");
  endtask

  task automatic test_illegal();
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, "illegal");
  endtask

  task automatic test_reset_midwrite();
    op = T_SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL midwrite strobe: got %b want 1", mem_write);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL midwrite reset: got mw=%b done=%b want 0 0",
               mem_write, instr_done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ir_write !== 1'b1 || alu_src_b !== 2'b10 || instret !== 32'd0) begin
      errors++;
      $display("FAIL midwrite recover: got ir=%b b=%b instret=%0d want 1 10 0",
               ir_write, alu_src_b, instret);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    exp_instret = 0;
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    logic [6:0] o;
    ops = '{T_LW, T_SW, T_R, T_I, T_JAL, T_BEQ, 7'b0000000};
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(6)];
      if (o == 7'b0000000) o = 7'($urandom_range(127));
      run_instr(o, 3'($urandom_range(7)), 1'($urandom_range(1)),
                1'($urandom_range(1)), $urandom_range(2),
                $urandom_range(3), "random");
    end
  endtask

  initial begin
    exp_instret = 0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu_decode();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_midwrite();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
